// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: drives the BTB lookup, issues in-order instruction fetches,
// pairs returned words with their PC/prediction for decode, and flushes on execute redirects.
module fetch_pc_gen #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h4000_0000,
   parameter int                    META_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] btb_predict_pc,
   input  logic [ADDR_WIDTH-1:0] btb_predicted_pc,
   input  logic                  btb_prediction,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_resp_valid,
   input  logic [31:0]           imem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [31:0]           out_inst,
   output logic                  out_pred_taken,
   output logic [ADDR_WIDTH-1:0] out_pred_target
);

   localparam int PW = (META_DEPTH > 1) ? $clog2(META_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   localparam ptr_t                  PTR_ZERO = ptr_t'(1'b0);
   localparam ptr_t                  PTR_ONE  = ptr_t'(1'b1);
   localparam cnt_t                  CNT_ZERO = cnt_t'(1'b0);
   localparam cnt_t                  CNT_ONE  = cnt_t'(1'b1);
   localparam cnt_t                  DEPTH_C  = cnt_t'(META_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(3'd4);
   localparam logic [ADDR_WIDTH-1:0] ADDR_Z   = {ADDR_WIDTH{1'b0}};

   logic [ADDR_WIDTH-1:0] pc_r;
   ptr_t                  head_r;
   ptr_t                  tail_r;
   ptr_t                  resp_ptr_r;
   cnt_t                  q_count_r;
   cnt_t                  inflight_r;
   cnt_t                  drop_cnt_r;

   logic [ADDR_WIDTH-1:0] ent_pc_r     [META_DEPTH];
   logic [ADDR_WIDTH-1:0] ent_target_r [META_DEPTH];
   logic [31:0]           ent_inst_r   [META_DEPTH];
   logic [META_DEPTH-1:0] ent_taken_r;
   logic [META_DEPTH-1:0] ent_dv_r;

   logic [ADDR_WIDTH-1:0] next_pc_s;
   logic                  req_valid_s;
   logic                  accept_s;
   logic                  out_valid_s;
   logic                  pop_s;
   logic                  drop_s;
   logic                  write_s;

   assign next_pc_s   = btb_prediction ? btb_predicted_pc : (pc_r + PC_STEP);
   // Reset is folded in so the request drops the moment reset asserts, not at the next edge.
   assign req_valid_s = !rst && !redirect_valid && (q_count_r < DEPTH_C) && (inflight_r < DEPTH_C);
   assign accept_s    = req_valid_s && imem_req_ready;
   assign out_valid_s = ent_dv_r[head_r] && !redirect_valid;
   assign pop_s       = out_valid_s && out_ready;
   assign drop_s      = imem_resp_valid && (drop_cnt_r != CNT_ZERO);
   assign write_s     = imem_resp_valid && (drop_cnt_r == CNT_ZERO);

   assign btb_predict_pc  = pc_r;
   assign imem_addr       = pc_r;
   assign imem_req_valid  = req_valid_s;
   assign out_valid       = out_valid_s;
   assign out_pc          = ent_pc_r[head_r];
   assign out_inst        = ent_inst_r[head_r];
   assign out_pred_taken  = ent_taken_r[head_r];
   assign out_pred_target = ent_target_r[head_r];

   // PC, fetch metadata queue, outstanding-request and drop counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r        <= RESET_PC;
         head_r      <= PTR_ZERO;
         tail_r      <= PTR_ZERO;
         resp_ptr_r  <= PTR_ZERO;
         q_count_r   <= CNT_ZERO;
         inflight_r  <= CNT_ZERO;
         drop_cnt_r  <= CNT_ZERO;
         ent_taken_r <= {META_DEPTH{1'b0}};
         ent_dv_r    <= {META_DEPTH{1'b0}};
         for (int i = 0; i < META_DEPTH; i++) begin
            ent_pc_r[i]     <= ADDR_Z;
            ent_target_r[i] <= ADDR_Z;
            ent_inst_r[i]   <= 32'h0000_0000;
         end
      end else begin
         if (accept_s && !imem_resp_valid) begin
            inflight_r <= inflight_r + CNT_ONE;
         end else if (!accept_s && imem_resp_valid) begin
            inflight_r <= inflight_r - CNT_ONE;
         end else begin
            inflight_r <= inflight_r;
         end

         if (redirect_valid) begin
            // A response landing this cycle is already retired, so it is not owed to the drop count.
            pc_r       <= redirect_pc;
            head_r     <= PTR_ZERO;
            tail_r     <= PTR_ZERO;
            resp_ptr_r <= PTR_ZERO;
            q_count_r  <= CNT_ZERO;
            ent_dv_r   <= {META_DEPTH{1'b0}};
            drop_cnt_r <= inflight_r - (imem_resp_valid ? CNT_ONE : CNT_ZERO);
         end else begin
            if (accept_s) begin
               pc_r                 <= next_pc_s;
               ent_pc_r[tail_r]     <= pc_r;
               ent_taken_r[tail_r]  <= btb_prediction;
               ent_target_r[tail_r] <= btb_prediction ? btb_predicted_pc : ADDR_Z;
               ent_dv_r[tail_r]     <= 1'b0;
               tail_r               <= tail_r + PTR_ONE;
            end else begin
               pc_r <= pc_r;
            end

            if (drop_s) begin
               drop_cnt_r <= drop_cnt_r - CNT_ONE;
            end else if (write_s) begin
               ent_inst_r[resp_ptr_r] <= imem_rdata;
               ent_dv_r[resp_ptr_r]   <= 1'b1;
               resp_ptr_r             <= resp_ptr_r + PTR_ONE;
            end else begin
               drop_cnt_r <= drop_cnt_r;
            end

            // Alloc and pop never target the same slot: alloc needs a non-full queue, pop a non-empty one.
            if (pop_s) begin
               ent_dv_r[head_r] <= 1'b0;
               head_r           <= head_r + PTR_ONE;
            end else begin
               head_r <= head_r;
            end

            if (accept_s && !pop_s) begin
               q_count_r <= q_count_r + CNT_ONE;
            end else if (!accept_s && pop_s) begin
               q_count_r <= q_count_r - CNT_ONE;
            end else begin
               q_count_r <= q_count_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: in-order memory with 1-cycle latency, a table BTB, a queue-based
// reference model checked every negedge, and directed scenarios with literal expectations.
module tb_fetch_pc_gen;

   localparam int          D = 4;
   localparam logic [31:0] K = 32'h1357_9BDF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] btb_predict_pc, btb_predicted_pc;
   logic        btb_prediction;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc, out_inst, out_pred_target;
   logic        out_pred_taken;

   logic        btb_en = 1'b0;
   logic [31:0] btb_hit_pc = 32'h0, btb_tgt = 32'h0;
   logic        mem_hold = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_pc_gen dut (
      .clk(clk), .rst(rst),
      .btb_predict_pc(btb_predict_pc), .btb_predicted_pc(btb_predicted_pc),
      .btb_prediction(btb_prediction),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target)
   );

   assign btb_prediction   = btb_en && (btb_predict_pc == btb_hit_pc);
   assign btb_predicted_pc = btb_tgt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Environment: logs of accepted requests and popped outputs, plus the in-order memory.
   logic [31:0] acc_log[$];
   logic [31:0] mem_q[$];
   logic [31:0] olog_pc[$];
   logic [31:0] olog_tg[$];
   logic        olog_tk[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (imem_req_valid && imem_req_ready) begin
            acc_log.push_back(imem_addr);
            mem_q.push_back(imem_addr);
         end
         if (out_valid && out_ready) begin
            olog_pc.push_back(out_pc);
            olog_tk.push_back(out_pred_taken);
            olog_tg.push_back(out_pred_target);
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (rst) begin
         mem_q.delete();
         imem_resp_valid = 1'b0;
         imem_rdata      = 32'h0;
      end else if (!mem_hold && mem_q.size() > 0) begin
         imem_resp_valid = 1'b1;
         imem_rdata      = mem_q.pop_front() ^ K;
      end else begin
         imem_resp_valid = 1'b0;
         imem_rdata      = 32'h0;
      end
   end

   // Reference model: list of fetched records in program order, filled by responses in order.
   typedef struct packed {
      logic [31:0] pc;
      logic        tk;
      logic [31:0] tg;
      logic        have;
   } rec_t;

   rec_t        mq[$];
   rec_t        m_rec;
   logic [31:0] m_pc;
   int          m_infl, m_drop;
   logic        m_req, m_out, m_tk, m_placed;

   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         m_pc   = 32'h4000_0000;
         m_infl = 0;
         m_drop = 0;
      end else begin
         m_req = !redirect_valid && (mq.size() < D) && (m_infl < D);
         m_out = !redirect_valid && (mq.size() > 0) && mq[0].have;
         chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
         chk("btb_predict_pc", btb_predict_pc, m_pc);
         if (m_req) chk("imem_addr", imem_addr, m_pc);
         chk("out_valid", {31'b0, out_valid}, {31'b0, m_out});
         if (m_out) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_inst", out_inst, mq[0].pc ^ K);
            chk("out_pred_taken", {31'b0, out_pred_taken}, {31'b0, mq[0].tk});
            chk("out_pred_target", out_pred_target, mq[0].tg);
         end
         m_tk = btb_en && (m_pc == btb_hit_pc);
         if (redirect_valid) begin
            m_drop = m_infl - (imem_resp_valid ? 1 : 0);
            m_infl = m_drop;
            mq.delete();
            m_pc = redirect_pc;
         end else begin
            if (imem_resp_valid) begin
               if (m_drop > 0) begin
                  m_drop--;
               end else begin
                  m_placed = 1'b0;
                  foreach (mq[i]) begin
                     if (!m_placed && !mq[i].have) begin
                        mq[i].have = 1'b1;
                        m_placed   = 1'b1;
                     end
                  end
                  chk("resp_has_slot", {31'b0, m_placed}, 32'd1);
               end
               m_infl--;
            end
            if (m_out && out_ready) void'(mq.pop_front());
            if (m_req && imem_req_ready) begin
               m_rec.pc   = m_pc;
               m_rec.tk   = m_tk;
               m_rec.tg   = m_tk ? btb_tgt : 32'h0;
               m_rec.have = 1'b0;
               mq.push_back(m_rec);
               m_pc = m_tk ? btb_tgt : m_pc + 32'd4;
               m_infl++;
            end
         end
      end
   end

   function automatic logic [31:0] acc_at(input int i);
      if (i < acc_log.size()) return acc_log[i];
      else return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] opc_at(input int i);
      if (i < olog_pc.size()) return olog_pc[i];
      else return 32'hDEAD_BEEF;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      #1 chk("redirect_out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1 redirect_valid = 1'b0;
   endtask

   int a0, o0;

   initial begin
      tick(2);
      chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      rst = 1'b0;
      #1 chk("reset_pc", imem_addr, 32'h4000_0000);
      chk("reset_req_after", {31'b0, imem_req_valid}, 32'd1);

      // Plain stream
      a0 = acc_log.size();
      tick(8);
      chk("stream_0", acc_at(a0), 32'h4000_0000);
      chk("stream_1", acc_at(a0 + 1), 32'h4000_0004);
      chk("stream_2", acc_at(a0 + 2), 32'h4000_0008);
      chk("stream_out_0", opc_at(0), 32'h4000_0000);

      // BTB hit
      btb_hit_pc = 32'h4000_0004;
      btb_tgt    = 32'h4000_0100;
      btb_en     = 1'b1;
      a0 = acc_log.size();
      o0 = olog_pc.size();
      redirect(32'h4000_0004);
      tick(8);
      chk("btb_req_0", acc_at(a0), 32'h4000_0004);
      chk("btb_req_1", acc_at(a0 + 1), 32'h4000_0100);
      chk("btb_req_2", acc_at(a0 + 2), 32'h4000_0104);
      chk("btb_out_pc", opc_at(o0), 32'h4000_0004);
      if (olog_tk.size() > o0 + 1) begin
         chk("btb_out_taken", {31'b0, olog_tk[o0]}, 32'd1);
         chk("btb_out_target", olog_tg[o0], 32'h4000_0100);
         chk("btb_next_taken", {31'b0, olog_tk[o0 + 1]}, 32'd0);
         chk("btb_next_target", olog_tg[o0 + 1], 32'h0);
      end else begin
         chk("btb_out_count", olog_tk.size(), o0 + 2);
      end
      btb_en = 1'b0;

      // Backpressure
      out_ready = 1'b0;
      a0 = acc_log.size();
      o0 = olog_pc.size();
      redirect(32'h4000_0300);
      tick(10);
      chk("bp_issued", acc_log.size() - a0, 32'd4);
      chk("bp_req_low", {31'b0, imem_req_valid}, 32'd0);
      out_ready = 1'b1;
      tick(12);
      for (int k = 0; k < 6; k++) chk("bp_resume_pc", opc_at(o0 + k), 32'h4000_0300 + 32'(4 * k));

      // Redirect with three requests in flight
      imem_req_ready = 1'b0;
      tick(3);
      mem_hold       = 1'b1;
      imem_req_ready = 1'b1;
      a0 = acc_log.size();
      redirect(32'h4000_0400);
      tick(3);
      imem_req_ready = 1'b0;
      chk("drop3_issued", acc_log.size() - a0, 32'd3);
      o0 = olog_pc.size();
      redirect(32'h4000_0200);
      mem_hold       = 1'b0;
      imem_req_ready = 1'b1;
      tick(12);
      chk("drop3_first_out", opc_at(o0), 32'h4000_0200);
      chk("drop3_second_out", opc_at(o0 + 1), 32'h4000_0204);

      // Redirect coinciding with a response, two in flight
      imem_req_ready = 1'b0;
      tick(3);
      mem_hold       = 1'b1;
      imem_req_ready = 1'b1;
      a0 = acc_log.size();
      redirect(32'h4000_0500);
      tick(2);
      imem_req_ready = 1'b0;
      chk("same_cycle_issued", acc_log.size() - a0, 32'd2);
      tick(1);
      o0 = olog_pc.size();
      mem_hold = 1'b0;
      redirect(32'h4000_0600);
      imem_req_ready = 1'b1;
      tick(10);
      chk("same_cycle_first_out", opc_at(o0), 32'h4000_0600);

      // Address wrap
      a0 = acc_log.size();
      redirect(32'hFFFF_FFFC);
      tick(6);
      chk("wrap_0", acc_at(a0), 32'hFFFF_FFFC);
      chk("wrap_1", acc_at(a0 + 1), 32'h0000_0000);
      chk("wrap_2", acc_at(a0 + 2), 32'h0000_0004);

      // Asynchronous reset mid-stream
      tick(2);
      @(posedge clk);
      #3;
      chk("pre_rst_req", {31'b0, imem_req_valid}, 32'd1);
      chk("pre_rst_out", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_req_drop", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_out_drop", {31'b0, out_valid}, 32'd0);
      tick(2);
      rst = 1'b0;
      a0 = acc_log.size();
      tick(4);
      chk("post_rst_0", acc_at(a0), 32'h4000_0000);
      chk("post_rst_1", acc_at(a0 + 1), 32'h4000_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
